// File: rtl/exec_pkg.sv
// Shared constants and the entry layout for the execute-result stage.
package exec_pkg;

    localparam int EXEC_WIDTH = 32;   // ALU result width
    localparam int EXEC_RC_W  = 5;    // destination register index width
    localparam int R31_IDX    = 31;   // hardwired-zero register, never written back

    // Bit positions inside the 3-bit flags field ({N,V,Z})
    localparam int FLAG_Z  = 0;
    localparam int FLAG_V  = 1;
    localparam int FLAG_N  = 2;
    localparam int FLAGS_W = 3;

    // One buffered result beat, most significant field first
    typedef struct packed {
        logic [EXEC_WIDTH-1:0] y;
        logic [FLAGS_W-1:0]    flags;
        logic [EXEC_RC_W-1:0]  rc;
        logic                  wr_en;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/exec_fifo2.sv
// Two-entry in-order buffer with flush; exposes the head and the newest entry.
module exec_fifo2 #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] head,
    output logic [DW-1:0] newest,
    output logic [1:0]    count
);
    import exec_pkg::*;

    logic [DW-1:0] mem_reg [2];
    logic          wr_ptr_reg;
    logic          rd_ptr_reg;
    logic [1:0]    count_reg;

    // Pointer and occupancy tracking; flush beats both push and pop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else if (flush) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage slots; cleared on reset so the data outputs read zero afterwards
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        // Capture the incoming beat into the slot the write pointer selects
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                mem_reg[gi] <= '0;
            end else if (push && !flush && (wr_ptr_reg == 1'(gi))) begin
                mem_reg[gi] <= din;
            end
        end
    end

    assign head   = mem_reg[rd_ptr_reg];
    assign newest = mem_reg[~wr_ptr_reg];   // slot written most recently
    assign count  = count_reg;

endmodule

// File: rtl/exec_result_stage.sv
// Execute-result stage: buffers ALU beats toward MEM, forwards the youngest
// result, masks writes to R31 and counts overflow events.
module exec_result_stage #(
    parameter int WIDTH = exec_pkg::EXEC_WIDTH,
    parameter int RC_W  = exec_pkg::EXEC_RC_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_z,
    input  logic             alu_v,
    input  logic             alu_n,
    input  logic [RC_W-1:0]  in_rc,
    input  logic             in_wr_en,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [2:0]       out_flags,
    output logic [RC_W-1:0]  out_rc,
    output logic             out_wr_en,
    output logic             fwd_valid,
    output logic [RC_W-1:0]  fwd_rc,
    output logic [WIDTH-1:0] fwd_y,
    input  logic             ovf_clr,
    output logic [15:0]      ovf_count
);
    import exec_pkg::*;

    // Packed as {y, flags, rc, wr_en}, the same order as entry_t
    localparam int EW = WIDTH + FLAGS_W + RC_W + 1;

    logic [1:0]         count;
    logic               accept;
    logic               dequeue;
    logic               wr_en_masked;
    logic [FLAGS_W-1:0] flags_in;
    logic [EW-1:0]      din;
    logic [EW-1:0]      head;
    logic [EW-1:0]      newest;
    logic [15:0]        ovf_count_reg;

    // Handshake decode; readiness depends only on occupancy (and is low in reset)
    always_comb begin
        in_ready     = reset_n && (count != 2'd2);
        out_valid    = (count != 2'd0);
        accept       = in_valid && in_ready;
        dequeue      = out_valid && out_ready;
        wr_en_masked = in_wr_en && (in_rc != RC_W'(R31_IDX));
        flags_in             = '0;
        flags_in[FLAG_Z]     = alu_z;
        flags_in[FLAG_V]     = alu_v;
        flags_in[FLAG_N]     = alu_n;
        din          = {alu_y, flags_in, in_rc, wr_en_masked};
    end

    exec_fifo2 #(
        .DW (EW)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (accept),
        .pop     (dequeue),
        .flush   (flush),
        .din     (din),
        .head    (head),
        .newest  (newest),
        .count   (count)
    );

    assign out_y     = head[EW-1 -: WIDTH];
    assign out_flags = head[RC_W+1 +: FLAGS_W];
    assign out_rc    = head[1 +: RC_W];
    assign out_wr_en = head[0];

    assign fwd_y     = newest[EW-1 -: WIDTH];
    assign fwd_rc    = newest[1 +: RC_W];
    assign fwd_valid = out_valid && newest[0];

    // Saturating overflow counter; clear wins, flushed beats are not counted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_count_reg <= 16'd0;
        end else if (ovf_clr) begin
            ovf_count_reg <= 16'd0;
        end else if (accept && alu_v && !flush && (ovf_count_reg != 16'hFFFF)) begin
            ovf_count_reg <= ovf_count_reg + 16'd1;
        end
    end

    assign ovf_count = ovf_count_reg;

endmodule

// File: tb/tb_exec_result_stage.sv
// Randomized scoreboard bench for exec_result_stage with directed scenarios.
module tb_exec_result_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_y;
    logic        alu_z, alu_v, alu_n;
    logic [4:0]  in_rc;
    logic        in_wr_en;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic [2:0]  out_flags;
    logic [4:0]  out_rc;
    logic        out_wr_en;
    logic        fwd_valid;
    logic [4:0]  fwd_rc;
    logic [31:0] fwd_y;
    logic        ovf_clr;
    logic [15:0] ovf_count;

    exec_result_stage #(.WIDTH(32), .RC_W(5)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_y     (alu_y),
        .alu_z     (alu_z),
        .alu_v     (alu_v),
        .alu_n     (alu_n),
        .in_rc     (in_rc),
        .in_wr_en  (in_wr_en),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_flags (out_flags),
        .out_rc    (out_rc),
        .out_wr_en (out_wr_en),
        .fwd_valid (fwd_valid),
        .fwd_rc    (fwd_rc),
        .fwd_y     (fwd_y),
        .ovf_clr   (ovf_clr),
        .ovf_count (ovf_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] y;
        logic [2:0]  flags;
        logic [4:0]  rc;
        logic        wr;
    } exp_t;

    exp_t exp_q[$];       // expected buffer contents, oldest first
    int   ovf_m  = 0;     // expected overflow count
    int   errors = 0;
    int   checks = 0;
    bit   quiet  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour for one clock edge, from the inputs in effect
    task automatic model_step();
        bit   acc;
        bit   deq;
        exp_t e;
        acc = in_valid && (exp_q.size() < 2);
        deq = out_ready && (exp_q.size() != 0);
        if (flush) begin
            exp_q.delete();
        end else begin
            if (deq) begin
                if (!quiet)
                    $display("txn out y=%0d flags=%b rc=%0d wr=%0b",
                             exp_q[0].y, exp_q[0].flags, exp_q[0].rc, exp_q[0].wr);
                void'(exp_q.pop_front());
            end
            if (acc) begin
                e.y     = alu_y;
                e.flags = {alu_n, alu_v, alu_z};
                e.rc    = in_rc;
                e.wr    = in_wr_en && (in_rc != 5'd31);
                exp_q.push_back(e);
            end
        end
        if (ovf_clr)
            ovf_m = 0;
        else if (acc && alu_v && !flush && ovf_m < 65535)
            ovf_m = ovf_m + 1;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset_n) model_step();
        #1;
    endtask

    task automatic beat(input logic [31:0] y, input logic v, input logic [4:0] rc,
                        input logic wr);
        in_valid = 1'b1; alu_y = y; alu_z = (y == 0); alu_v = v; alu_n = 1'b0;
        in_rc = rc; in_wr_en = wr;
    endtask

    task automatic idle();
        in_valid = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
    endtask

    // Monitor: compares DUT outputs against the expected queue every cycle
    always @(negedge clk) begin
        if (reset_n) begin
            chk("out_valid", out_valid, exp_q.size() != 0);
            chk("in_ready", in_ready, exp_q.size() < 2);
            chk("ovf_count", ovf_count, ovf_m);
            if (exp_q.size() != 0) begin
                chk("out_y", out_y, exp_q[0].y);
                chk("out_flags", out_flags, exp_q[0].flags);
                chk("out_rc", out_rc, exp_q[0].rc);
                chk("out_wr_en", out_wr_en, exp_q[0].wr);
                chk("fwd_valid", fwd_valid, exp_q[$].wr);
                if (exp_q[$].wr) begin
                    chk("fwd_y", fwd_y, exp_q[$].y);
                    chk("fwd_rc", fwd_rc, exp_q[$].rc);
                end
            end else begin
                chk("fwd_valid_empty", fwd_valid, 1'b0);
            end
        end
    end

    initial begin
        reset_n = 1'b0; out_ready = 1'b0;
        in_valid = 0; alu_y = 0; alu_z = 0; alu_v = 0; alu_n = 0;
        in_rc = 0; in_wr_en = 0; flush = 0; ovf_clr = 0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_fwd_valid", fwd_valid, 1'b0);
        chk("rst_ovf", ovf_count, 16'd0);
        chk("rst_out_y", out_y, 32'd0);
        chk("rst_fwd_y", fwd_y, 32'd0);
        cycle(); cycle();
        reset_n = 1'b1;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);

        // Single ADD beat, one-cycle latency
        out_ready = 1'b1;
        beat(32'd103, 1'b0, 5'd3, 1'b1);
        cycle();
        idle();
        cycle(); cycle();

        // Two held beats, then release in order
        out_ready = 1'b0;
        beat(32'd67, 1'b0, 5'd4, 1'b1); cycle();
        beat(32'd36, 1'b0, 5'd5, 1'b1); cycle();
        idle(); cycle(); cycle();
        out_ready = 1'b1; cycle(); cycle(); cycle();

        // R31 destination suppresses write-back and forwarding
        beat(32'd77, 1'b0, 5'd31, 1'b1); cycle();
        idle(); cycle(); cycle();

        // Overflow counting and clear-wins
        beat(32'd1, 1'b1, 5'd1, 1'b1); cycle();
        beat(32'd2, 1'b1, 5'd2, 1'b1); cycle();
        beat(32'd3, 1'b1, 5'd3, 1'b1); cycle();
        idle(); cycle();
        chk("ovf_three", ovf_count, 16'd3);
        beat(32'd4, 1'b1, 5'd4, 1'b1); ovf_clr = 1'b1; cycle();
        idle(); cycle();
        chk("ovf_cleared", ovf_count, 16'd0);
        cycle();

        // Flush a full buffer while a beat is offered
        out_ready = 1'b0;
        beat(32'd11, 1'b1, 5'd6, 1'b1); cycle();
        beat(32'd12, 1'b1, 5'd7, 1'b1); cycle();
        beat(32'd13, 1'b1, 5'd8, 1'b1); flush = 1'b1; cycle();
        idle(); out_ready = 1'b1; cycle(); cycle();
        chk("flush_empty", out_valid, 1'b0);

        // Reset asserted while a beat is waiting
        out_ready = 1'b0;
        beat(32'd21, 1'b1, 5'd9, 1'b1); cycle();
        beat(32'd22, 1'b1, 5'd10, 1'b1); cycle();
        idle();
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_ovf", ovf_count, 16'd0);
        chk("midrst_in_ready", in_ready, 1'b0);
        chk("midrst_fwd_valid", fwd_valid, 1'b0);
        exp_q.delete(); ovf_m = 0;
        cycle(); cycle();
        reset_n = 1'b1;
        out_ready = 1'b1;
        cycle();

        // Saturation: stream overflow beats past the counter limit
        quiet = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            beat(i, 1'b1, 5'(i % 31), 1'b1);
            cycle();
        end
        idle(); cycle();
        chk("ovf_saturated", ovf_count, 16'hFFFF);
        quiet = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            alu_y     = $urandom;
            alu_z     = $urandom_range(0, 1);
            alu_v     = $urandom_range(0, 1);
            alu_n     = $urandom_range(0, 1);
            in_rc     = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            in_wr_en  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            ovf_clr   = ($urandom_range(0, 24) == 0);
            cycle();
        end
        idle(); out_ready = 1'b1;
        cycle(); cycle(); cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exec_result_stage.md
EXEC_RESULT_STAGE -- requirements
Module: exec_result_stage

Interface
REQ-001 Parameter WIDTH, 32, data width of ALU result Y.
REQ-002 Parameter RC_W, 5, destination register index width.
REQ-003 The block SHALL use one clock and an asynchronous active-low reset, with ports as below.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  ALU result beat present.
REQ-007 in_ready  output  1  stage can accept a beat.
REQ-008 alu_y  input  WIDTH  ALU result Y.
REQ-009 alu_z, alu_v, alu_n  input  1 each  ALU Z/V/N flags.
REQ-010 in_rc  input  RC_W  destination register.
REQ-011 in_wr_en  input  1  instruction writes back.
REQ-012 flush  input  1  synchronous pipeline flush.
REQ-013 out_valid  output  1  head beat present.
REQ-014 out_ready  input  1  downstream (MEM stage) accepts the head.
REQ-015 out_y  output  WIDTH; out_flags  output  3  {N,V,Z}; out_rc  output  RC_W; out_wr_en  output  1.
REQ-016 fwd_valid  output  1; fwd_rc  output  RC_W; fwd_y  output  WIDTH: bypass of youngest entry to operand select.
REQ-017 ovf_clr  input  1; ovf_count  output  16  saturating overflow-event counter.

Function
REQ-018 The block SHALL hold a 2-entry in-order buffer; in_ready = (count < 2), derived from registered state only.
REQ-019 Accept = in_valid && in_ready; dequeue = out_valid && out_ready; out_valid = (count != 0).
REQ-020 Latency: a beat accepted in cycle N SHALL appear on out_* in cycle N+1 when the buffer was empty.
REQ-021 Simultaneous accept and dequeue SHALL leave count unchanged and preserve order; pointers wrap modulo 2.
REQ-022 Accept when full SHALL be impossible; in_valid while in_ready=0 SHALL be ignored (upstream holds).
REQ-023 out_* SHALL be held stable while out_valid && !out_ready.
REQ-024 Stored wr_en SHALL be forced 0 when in_rc == 31 (R31 is never written).
REQ-025 fwd_* SHALL present the most recently accepted valid entry; fwd_valid = count != 0 && that entry's wr_en.
REQ-026 ovf_count SHALL increment on each accepted beat with alu_v=1, saturating at 16'hFFFF.
REQ-027 ovf_clr SHALL zero ovf_count next cycle; clear wins over a simultaneous increment.
REQ-028 flush SHALL empty the buffer next cycle (count, pointers 0); a beat presented in the flush cycle is dropped and not counted; flush has priority over accept and dequeue.

Reset
REQ-029 On reset_n low, count, pointers, ovf_count SHALL be 0 immediately; out_valid=0, fwd_valid=0, in_ready=0 during reset.
REQ-030 in_ready SHALL be 1 in the first cycle after reset_n deasserts; buffer data SHALL be don't-care but out_y/fwd_y SHALL read 0 after reset.
REQ-031 Reset asserted mid-transfer SHALL discard all buffered beats with no partial output.

Structure
REQ-032 Package exec_pkg SHALL hold WIDTH, RC_W, R31 index constant, flag bit indices (Z=0, V=1, N=2) and the packed entry typedef {y, flags, rc, wr_en}.
REQ-033 The 2-entry buffer SHALL be a sub-module named exec_fifo2; counter and R31 masking stay in the top.

Verification
REQ-034 ADD beat alu_y=103, Z=0,V=0,N=0, rc=3, wr_en=1, out_ready=1 -> out_y=103, out_flags=3'b000, out_wr_en=1 one cycle later.
REQ-035 Two beats (y=67, y=36) with out_ready=0 -> in_ready=0 after second; release out_ready -> 67 then 36 in order; fwd_y=36 while both held.
REQ-036 Beat rc=31, wr_en=1 -> out_wr_en=0, fwd_valid=0.
REQ-037 Three beats with alu_v=1, then ovf_clr with a fourth V beat in same cycle -> ovf_count 3 then 0.
REQ-038 Buffer full, flush with in_valid=1 -> next cycle out_valid=0, count 0, flushed beat never appears.
REQ-039 reset_n low while out_valid=1 -> out_valid=0 asynchronously, ovf_count=0.
